change_log_fifo: RTL
====================

// Module: change_log_fifo
// PURPOSE
//  Synthesisable, clocked consumer for value-change events: the hardware counterpart of a $monitor line.
//  - Samples a watched bus every enabled clock.
//  - Logs the first sample and every later change as {timestamp, value} into a small FIFO.
//  - A ready/valid reader drains the FIFO.
//  - Sits beside scheduling examples, e.g. recording the settled a/b/c values of a comb network.
// PARAMETERS
//  W      3   width of watched bus
//  DEPTH  4   FIFO entries (power of two, >=2)
//  TSW    8   timestamp width; counts enabled cycles, wraps modulo 2**TSW
// PORTS
//  clk         in   1             clock, rising edge
//  rst_n       in   1             asynchronous active-low reset
//  en_i        in   1             sample enable; when 0: no sampling, no timestamp advance
//  watch_i     in   W             watched bus
//  rd_ready_i  in   1             reader accepts head entry
//  rd_valid_o  out  1             FIFO non-empty
//  rd_data_o   out  TSW+W         head entry {ts, value}; value in LSBs
//  count_o     out  clog2(DEPTH)+1  current occupancy
//  overflow_o  out  1             sticky: an event was dropped
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert)
//   - rd_valid_o=0, rd_data_o=0, count_o=0, overflow_o=0.
//   - ts=0, prev=0, primed=0, FIFO pointers=0.
//  Timestamp
//   - ts is the stamp of the current enabled cycle.
//   - ts+1 (wrapping) after each enabled clock.
//   - First enabled cycle after reset gets ts=0.
//  Event detect, enabled cycles only
//   - evt = !primed || (watch_i !== prev).
//   - Case inequality, so X/Z transitions log in simulation.
//   - On every enabled edge: prev<=watch_i, primed<=1, whether or not the push is accepted.
//  Push
//   - evt pushes {ts, watch_i}.
//   - Full and no pop this edge: entry dropped, overflow_o<=1.
//   - overflow_o clears only on reset.
//  Pop
//   - rd_valid_o && rd_ready_i at an edge removes the head.
//   - rd_ready_i while empty is ignored.
//  Simultaneous push+pop
//   - When full: pop frees the slot, push accepted, count unchanged, no overflow.
//   - When empty: push is stored; the pop is a no-op (no fall-through).
//  Latency
//   - Change present before edge k is logged at edge k.
//   - rd_valid_o/rd_data_o reflect it after edge k (registered, 1 cycle).
//  Outputs
//   - rd_data_o = mem[rd_ptr] (registered FIFO storage); don't-care when rd_valid_o=0.
//   - count_o is exact after every edge.
//  Pointers
//   - Wrap modulo DEPTH.
//   - full = (count==DEPTH); empty = (count==0).
//  Reset mid-operation: contents discarded; next enabled sample re-logs as first event, ts=0.
//  en_i=0: pops still serviced; no pushes.
// TESTING
//  1. Reset, en=1, watch=3'b011 held 5 cycles -> exactly one entry {ts=0, 011}; count=1.
//  2. Enabled ticks 0..3 with watch 000,001,001,111 -> entries {0,000},{1,001},{3,111}.
//  3. DEPTH=4, rd_ready=0, watch changes on 6 consecutive enabled cycles -> count=4, overflow=1,
//     head ts=0; after draining, no 5th entry.
//  4. Full FIFO, change + rd_ready same edge -> count stays 4, overflow stays 0,
//     new entry at tail, old head gone.
//  5. TSW=2, change every cycle for 6 enabled cycles while draining -> stamps 0,1,2,3,0,1.
//  6. Fill 3 entries, pulse rst_n low between edges -> outputs 0 immediately (async);
//     next sample logged with ts=0.

Source files
------------

// File: rtl/change_log_fifo.sv
// Logs {timestamp, value} whenever the watched bus changes on an enabled cycle; entry visible 1 cycle after its edge.
// Reader drains via ready/valid; a push into a full FIFO with no pop is dropped and sets sticky overflow.
module change_log_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    parameter int TSW   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [W-1:0]              watch_i,
    input  logic                      rd_ready_i,
    output logic                      rd_valid_o,
    output logic [TSW+W-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [TSW-1:0] ts;
        logic [W-1:0]   val;
    } entry_t;

    logic [TSW-1:0] ts_q, ts_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           primed_q, primed_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];

    logic evt, full, pop, push;

    always_comb begin
        // Case inequality so X/Z transitions are logged in simulation.
        evt  = en_i && (!primed_q || (watch_i !== prev_q));
        full = (count_q == CW'(DEPTH));
        pop  = (count_q != '0) && rd_ready_i;
        // A pop on a full FIFO frees the slot the same edge.
        push = evt && (!full || pop);

        ts_d     = ts_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        if (en_i) begin
            ts_d     = ts_q + 1'b1;
            prev_d   = watch_i;
            primed_d = 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{ts: ts_q, val: watch_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (evt && !push) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q     <= ts_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule
